// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the PC, requests words from the cache, queues them.
// Define JAL_PREDECODE_EN to redirect the PC on JAL at fetch time.
module inst_fetcher #(
   parameter int          IQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear_up,
   input  logic [31:0] rob_new_pc,
   output logic        should_fetch,
   output logic [31:0] pc,
   input  logic        fetch_ready,
   input  logic [31:0] inst,
   input  logic [31:0] inst_addr,
   output logic        iq_valid,
   output logic [31:0] iq_inst,
   output logic [31:0] iq_pc,
   output logic [31:0] iq_pred_pc,
   input  logic        iq_pop
);

   localparam int PW = $clog2(IQ_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t          state;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [31:0]     mem_inst [IQ_DEPTH];
   logic [31:0]     mem_pc   [IQ_DEPTH];
   logic [31:0]     mem_pred [IQ_DEPTH];

   logic            live;
   logic            pop_ok;
   logic            accept;
   logic            has_space;
   logic [CW-1:0]   count_nxt;
   logic [31:0]     next_pc;

   assign live   = rdy_in && !rob_clear_up;
   assign pop_ok = live && iq_pop && (count != '0);
   assign accept = live && (state == REQ) && fetch_ready &&
                   (inst_addr == pc) &&
                   ((count != CW'(IQ_DEPTH)) || pop_ok);

   assign count_nxt = count + CW'(accept) - CW'(pop_ok);
   assign has_space = count_nxt < CW'(IQ_DEPTH);

`ifdef JAL_PREDECODE_EN
   logic [31:0] jal_imm;
   assign jal_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                     inst[20], inst[30:21], 1'b0};
   assign next_pc = (inst[6:0] == 7'b1101111) ? pc + jal_imm
                                              : pc + 32'd4;
`else
   assign next_pc = pc + 32'd4;
`endif

   // Drop the request the same cycle the cache answers so it never re-samples
   assign should_fetch = live && (state == REQ) && !fetch_ready;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         if (rob_clear_up) begin
            state <= REQ;
            pc    <= rob_new_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            count <= count_nxt;
            if (pop_ok)
               head <= head + PW'(1);
            if (accept) begin
               tail <= tail + PW'(1);
               pc   <= next_pc;
            end
            if (accept || state == IDLE)
               state <= has_space ? REQ : IDLE;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) begin
         mem_inst[tail] <= inst;
         mem_pc[tail]   <= pc;
         mem_pred[tail] <= next_pc;
      end
   end

   assign iq_valid   = (count != '0);
   assign iq_inst    = iq_valid ? mem_inst[head] : '0;
   assign iq_pc      = iq_valid ? mem_pc[head]   : '0;
   assign iq_pred_pc = iq_valid ? mem_pred[head] : '0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized scoreboard bench for inst_fetcher against a queue-level model.
// Build with +define+JAL_PREDECODE_EN to exercise the JAL redirect.
module tb_inst_fetcher;

   localparam int D = 4;

   logic        clk_in = 0;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_clear_up;
   logic [31:0] rob_new_pc;
   logic        should_fetch;
   logic [31:0] pc;
   logic        fetch_ready;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        iq_valid;
   logic [31:0] iq_inst;
   logic [31:0] iq_pc;
   logic [31:0] iq_pred_pc;
   logic        iq_pop;

   inst_fetcher #(.IQ_DEPTH(D), .RESET_PC(32'h0)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rob_clear_up(rob_clear_up), .rob_new_pc(rob_new_pc),
      .should_fetch(should_fetch), .pc(pc),
      .fetch_ready(fetch_ready), .inst(inst), .inst_addr(inst_addr),
      .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
      .iq_pred_pc(iq_pred_pc), .iq_pop(iq_pop)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [31:0] i;
      logic [31:0] p;
      logic [31:0] n;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] m_pc;
   logic        m_req;
   int          m_cnt;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] p,
                                            input logic [31:0] w);
`ifdef JAL_PREDECODE_EN
      if (w[6:0] == 7'h6f) begin
         int off;
         off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 +
               int'(w[19:12]) * 4096 - (w[31] ? (1 << 20) : 0);
         return p + off;
      end
`endif
      return p + 32'd4;
   endfunction

   // Model of what the fetcher does at the edge just taken
   task automatic model_edge();
      bit popk, acc;
      int nc;
      if (!rdy_in) return;
      if (rob_clear_up) begin
         m_pc  = rob_new_pc;
         m_req = 1;
         m_cnt = 0;
         exp_q.delete();
         return;
      end
      popk = iq_pop && (m_cnt > 0);
      acc  = m_req && fetch_ready && (inst_addr == m_pc) &&
             (m_cnt < D || popk);
      nc   = m_cnt - int'(popk) + int'(acc);
      if (acc) begin
         ent_t e;
         e.i = inst;
         e.p = m_pc;
         e.n = ref_next(m_pc, inst);
         exp_q.push_back(e);
         m_pc  = e.n;
         m_req = (nc < D);
      end else if (!m_req) begin
         m_req = (nc < D);
      end
      m_cnt = nc;
   endtask

   task automatic quiet();
      rdy_in       = 1;
      rob_clear_up = 0;
      rob_new_pc   = 0;
      fetch_ready  = 0;
      inst         = 0;
      inst_addr    = 0;
      iq_pop       = 0;
   endtask

   task automatic cyc(input bit r, input bit fl, input logic [31:0] np,
                      input bit fr, input logic [31:0] w,
                      input logic [31:0] a, input bit po);
      rdy_in       = r;
      rob_clear_up = fl;
      rob_new_pc   = np;
      fetch_ready  = fr;
      inst         = w;
      inst_addr    = a;
      iq_pop       = po;
      @(posedge clk_in);
      #1;
      model_edge();
   endtask

   task automatic do_reset();
      quiet();
      rst_in = 1;
      m_pc   = 32'h0;
      m_req  = 0;
      m_cnt  = 0;
      exp_q.delete();
      @(posedge clk_in);
      #2;
      rst_in = 0;
   endtask

   task automatic settle();
      quiet();
      #1;
   endtask

   // Monitor: compares every cycle, pops the scoreboard on consumption
   always @(negedge clk_in) begin
      chk("should_fetch", {31'b0, should_fetch},
          {31'b0, !rst_in && m_req && rdy_in && !rob_clear_up &&
                  !fetch_ready});
      chk("pc", pc, m_pc);
      chk("iq_valid", {31'b0, iq_valid}, {31'b0, m_cnt != 0});
      if (m_cnt == 0) begin
         chk("iq_inst_empty", iq_inst, 32'h0);
         chk("iq_pc_empty", iq_pc, 32'h0);
         chk("iq_pred_empty", iq_pred_pc, 32'h0);
      end else if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_underrun: got %0d expected >0", 0);
      end else begin
         chk("iq_inst", iq_inst, exp_q[0].i);
         chk("iq_pc", iq_pc, exp_q[0].p);
         chk("iq_pred_pc", iq_pred_pc, exp_q[0].n);
         if (iq_pop && rdy_in && !rob_clear_up && !rst_in)
            void'(exp_q.pop_front());
      end
   end

   initial begin
      logic [31:0] w, a;
      bit fr, po, fl, r;
      do_reset();

      cyc(1, 0, 0, 0, 0, 0, 0);
      settle();
      chk("t_req_sf", {31'b0, should_fetch}, 32'd1);
      chk("t_req_pc", pc, 32'h0);
      chk("t_req_valid", {31'b0, iq_valid}, 32'd0);

      cyc(1, 0, 0, 1, 32'h13, 32'h0, 0);
      settle();
      chk("t_first_inst", iq_inst, 32'h13);
      chk("t_first_pc", iq_pc, 32'h0);
      chk("t_first_pred", iq_pred_pc, 32'h4);
      chk("t_first_nextpc", pc, 32'h4);

      for (int k = 1; k < 4; k++)
         cyc(1, 0, 0, 1, 32'h13, 32'(4 * k), 0);
      settle();
      chk("t_full_sf", {31'b0, should_fetch}, 32'd0);
      chk("t_full_pc", pc, 32'h10);

      cyc(1, 0, 0, 0, 0, 0, 1);
      settle();
      chk("t_refill_sf", {31'b0, should_fetch}, 32'd1);
      chk("t_refill_pc", pc, 32'h10);

      cyc(1, 0, 0, 1, 32'h13, 32'h10, 1);
      settle();
      chk("t_pushpop_head", iq_pc, 32'h8);
      chk("t_pushpop_pc", pc, 32'h14);
      cyc(1, 0, 0, 1, 32'h13, 32'h14, 0);
      settle();
      chk("t_full2_sf", {31'b0, should_fetch}, 32'd0);

      cyc(1, 1, 32'h1000, 1, 32'h13, 32'h18, 1);
      settle();
      chk("t_flush_valid", {31'b0, iq_valid}, 32'd0);
      chk("t_flush_pc", pc, 32'h1000);
      cyc(1, 0, 0, 1, 32'h13, 32'h8, 0);
      settle();
      chk("t_stale_valid", {31'b0, iq_valid}, 32'd0);
      chk("t_stale_pc", pc, 32'h1000);
      cyc(1, 0, 0, 1, 32'h13, 32'h1000, 0);
      settle();
      chk("t_redir_pc", iq_pc, 32'h1000);
      chk("t_redir_next", pc, 32'h1004);

      cyc(1, 1, 32'h20, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 32'h0100006F, 32'h20, 0);
      settle();
`ifdef JAL_PREDECODE_EN
      chk("t_jal_pred", iq_pred_pc, 32'h30);
      chk("t_jal_pc", pc, 32'h30);
`else
      chk("t_jal_pred", iq_pred_pc, 32'h24);
      chk("t_jal_pc", pc, 32'h24);
`endif

      cyc(0, 0, 0, 1, 32'h13, pc, 1);
      cyc(0, 1, 32'h500, 0, 0, 0, 1);
      settle();
      chk("t_hold_pc", iq_pc, 32'h20);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            continue;
         end
         r  = ($urandom_range(0, 9) != 0);
         fl = ($urandom_range(0, 39) == 0);
         po = ((i / 300) % 2 == 0) ? ($urandom_range(0, 9) == 0)
                                   : ($urandom_range(0, 9) < 6);
         w  = $urandom;
         if ($urandom_range(0, 3) == 0)
            w[6:0] = 7'h6f;
         fr = m_req ? ($urandom_range(0, 9) < 6)
                    : ($urandom_range(0, 9) == 0);
         a  = m_pc;
         if ($urandom_range(0, 6) == 0)
            a = m_pc ^ (32'h4 << $urandom_range(0, 20));
         cyc(r, fl, {$urandom_range(0, 32'hffff), 2'b00}, fr, w, a, po);
      end

      settle();
      @(posedge clk_in);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
